// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
package updown_counter_pkg;

  // Direction encoding on the dir input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Legal configurations: the state must fit WIDTH bits and the count range
  // must contain at least two states.
  function automatic bit params_legal(input int width, input int modulus);
    return (width >= 1) && (width <= 30) &&
           (modulus >= 2) && (modulus <= (1 << width));
  endfunction

  // Binary-reflected Gray code of value, limited to the low width bits.
  function automatic logic [31:0] to_gray(input logic [31:0] value, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value ^ (value >> 1)) & mask;
  endfunction

endpackage

// File: rtl/updown_counter_fsm_next.sv
// counter_next_logic: combinational next-state and terminal-count logic.
// Build option: UDC_SATURATE_EN makes the count hold at its limits instead of wrapping.
module counter_next_logic
  import updown_counter_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic [WIDTH-1:0] s,
  input  logic             x,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] n,
  output logic             tc
);

  // Comparisons run one bit wider than the state so that MODULUS = 2**WIDTH
  // is representable and no wrap ever comes from truncation.
  localparam int             WX    = WIDTH + 1;
  localparam logic [WX-1:0]  MOD_X = WX'(MODULUS);
  localparam logic [WX-1:0]  MAX_X = WX'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);

  logic [WX-1:0] s_ext;
  logic [WX-1:0] d_ext;
  logic          at_limit;

  assign s_ext    = {1'b0, s};
  assign d_ext    = {1'b0, d};
  assign at_limit = (dir == DIR_UP) ? (s_ext == MAX_X) : (s_ext == '0);

  // Priority: load, then count, then hold.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    n  = s;
    tc = 1'b0;
    if (ld) begin
      n = (d_ext < MOD_X) ? d : '0;
    end else if (x) begin
      tc = at_limit;
      if (at_limit) begin
`ifdef UDC_SATURATE_EN
        n = s;
`else
        n = (dir == DIR_UP) ? '0 : MAX_W;
`endif
      end else if (dir == DIR_DOWN) begin
        n = s - WIDTH'(1);
      end else begin
        n = s + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter_fsm.sv
// updown_counter_fsm: modulo-N up/down counter with load, terminal count and
// optional Gray output. Build option: UDC_SATURATE_EN (saturate instead of wrap).
module updown_counter_fsm
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MODULUS  = 4,
  parameter int GRAY_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] n,
  output logic             tc
);

  generate
    if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
      $error("updown_counter_fsm: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] n_raw;
  logic             tc_raw;

  counter_next_logic #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .s   (s),
    .x   (x),
    .dir (dir),
    .ld  (ld),
    .d   (d),
    .n   (n_raw),
    .tc  (tc_raw)
  );

  // While reset is held the visible next state and flag read as zero.
  assign n  = rst ? n_raw : '0;
  assign tc = rst & tc_raw;

  // State register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment to avoid update races.
    if (!rst) s <= '0;
    else      s <= n_raw;
  end

  // Moore output encoder.
  generate
    if (GRAY_OUT != 0) begin : g_gray
      assign y = WIDTH'(to_gray(32'(s), WIDTH));
    end else begin : g_bin
      assign y = s;
    end
  endgenerate

endmodule

// File: tb/tb_updown_counter_fsm.sv
// Self-checking bench: three configurations driven in parallel and compared
// against a modular-arithmetic reference model.
module tb_updown_counter_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x = 1'b0, dir = 1'b0, ld = 1'b0;
  logic [2:0] d = '0;

  logic [1:0] s0, n0, y0, s1, n1, y1;
  logic [2:0] s2, n2, y2;
  logic       tc0, tc1, tc2;

  logic [2:0] gs[3], gn[3], gy[3];
  logic       gtc[3];

  int checks = 0;
  int fails  = 0;
  int ms[3];
  int mod_n[3] = '{4, 3, 8};
  int wd[3]    = '{2, 2, 3};

  always #5 clk = ~clk;

  updown_counter_fsm #(.WIDTH(2), .MODULUS(4), .GRAY_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .x(x), .dir(dir), .ld(ld), .d(d[1:0]),
    .y(y0), .s(s0), .n(n0), .tc(tc0));
  updown_counter_fsm #(.WIDTH(2), .MODULUS(3), .GRAY_OUT(0)) dut1 (
    .clk(clk), .rst(rst), .x(x), .dir(dir), .ld(ld), .d(d[1:0]),
    .y(y1), .s(s1), .n(n1), .tc(tc1));
  updown_counter_fsm #(.WIDTH(3), .MODULUS(8), .GRAY_OUT(1)) dut2 (
    .clk(clk), .rst(rst), .x(x), .dir(dir), .ld(ld), .d(d),
    .y(y2), .s(s2), .n(n2), .tc(tc2));

  assign gs[0] = {1'b0, s0}; assign gn[0] = {1'b0, n0}; assign gy[0] = {1'b0, y0};
  assign gs[1] = {1'b0, s1}; assign gn[1] = {1'b0, n1}; assign gy[1] = {1'b0, y1};
  assign gs[2] = s2;         assign gn[2] = n2;         assign gy[2] = y2;
  assign gtc[0] = tc0; assign gtc[1] = tc1; assign gtc[2] = tc2;

  // Reference model: counting is modular arithmetic on the integer state.
  function automatic int model_next(input int i);
    int dd;
    dd = int'(d) % (1 << wd[i]);
    if (!rst) return 0;
    if (ld) return (dd < mod_n[i]) ? dd : 0;
    if (!x) return ms[i];
`ifdef UDC_SATURATE_EN
    if (dir == 1'b0) return (ms[i] + 1 < mod_n[i]) ? ms[i] + 1 : ms[i];
    return (ms[i] > 0) ? ms[i] - 1 : 0;
`else
    if (dir == 1'b0) return (ms[i] + 1) % mod_n[i];
    return (ms[i] + mod_n[i] - 1) % mod_n[i];
`endif
  endfunction

  function automatic bit model_tc(input int i);
    return rst && !ld && x && ((dir == 1'b0) ? (ms[i] == mod_n[i] - 1) : (ms[i] == 0));
  endfunction

  function automatic int model_y(input int i);
    return (i == 2) ? (ms[i] ^ (ms[i] >> 1)) : ms[i];
  endfunction

  task automatic set_inputs(input logic r, input logic l, input logic xx,
                            input logic dr, input logic [2:0] dd);
    @(negedge clk);
    rst = r; ld = l; x = xx; dir = dr; d = dd;
    #1;
  endtask

  task automatic tick();
    int nx[3];
    for (int i = 0; i < 3; i++) nx[i] = model_next(i);
    @(posedge clk);
    for (int i = 0; i < 3; i++) ms[i] = nx[i];
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; x = 1'b1; ld = 1'b0; dir = 1'b0; d = '0;
    for (int i = 0; i < 3; i++) ms[i] = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (gs[i] !== 3'd0) begin fails++; $display("FAIL reset_s dut%0d got %0d want 0", i, gs[i]); end
        checks++; if (gy[i] !== 3'd0) begin fails++; $display("FAIL reset_y dut%0d got %0d want 0", i, gy[i]); end
        checks++; if (gn[i] !== 3'd0) begin fails++; $display("FAIL reset_n dut%0d got %0d want 0", i, gn[i]); end
        checks++; if (gtc[i] !== 1'b0) begin fails++; $display("FAIL reset_tc dut%0d got %0b want 0", i, gtc[i]); end
      end
      tick();
    end
  endtask

  task automatic test_wrap_up();
`ifdef UDC_SATURATE_EN
    int exp_s[5] = '{1, 2, 3, 3, 3};
`else
    int exp_s[5] = '{1, 2, 3, 0, 1};
`endif
    int prev = 0;
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (gtc[0] !== (prev == 3)) begin fails++; $display("FAIL wrap_tc step%0d got %0b want %0b", k, gtc[0], prev == 3); end
      tick();
      checks++; if (gs[0] !== 3'(exp_s[k])) begin fails++; $display("FAIL wrap_s step%0d got %0d want %0d", k, gs[0], exp_s[k]); end
      checks++; if (gy[0] !== 3'(exp_s[k])) begin fails++; $display("FAIL wrap_y step%0d got %0d want %0d", k, gy[0], exp_s[k]); end
      prev = exp_s[k];
    end
  endtask

  task automatic test_mod3_down();
`ifdef UDC_SATURATE_EN
    int exp_s[4] = '{0, 0, 0, 0};
`else
    int exp_s[4] = '{2, 1, 0, 2};
`endif
    int prev = 0;
    set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    set_inputs(1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (gtc[1] !== (prev == 0)) begin fails++; $display("FAIL mod3_tc step%0d got %0b want %0b", k, gtc[1], prev == 0); end
      tick();
      checks++; if (gs[1] !== 3'(exp_s[k])) begin fails++; $display("FAIL mod3_s step%0d got %0d want %0d", k, gs[1], exp_s[k]); end
      prev = exp_s[k];
    end
  endtask

  task automatic test_load_priority();
    set_inputs(1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      checks++; if (gtc[i] !== 1'b0) begin fails++; $display("FAIL load_tc dut%0d got %0b want 0", i, gtc[i]); end
      checks++; if (gn[i] !== 3'd2) begin fails++; $display("FAIL load_n dut%0d got %0d want 2", i, gn[i]); end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (gs[i] !== 3'd2) begin fails++; $display("FAIL load_s dut%0d got %0d want 2", i, gs[i]); end
    end
    set_inputs(1'b1, 1'b1, 1'b1, 1'b1, 3'd3);
    tick();
    checks++; if (gs[1] !== 3'd0) begin fails++; $display("FAIL load_clamp got %0d want 0", gs[1]); end
    checks++; if (gs[0] !== 3'd3) begin fails++; $display("FAIL load_in_range got %0d want 3", gs[0]); end
  endtask

  task automatic test_gray();
    int exp_y[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    logic [2:0] prev;
    set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    checks++; if (gy[2] !== 3'd0) begin fails++; $display("FAIL gray_start got %0d want 0", gy[2]); end
    prev = gy[2];
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (gy[2] !== 3'(exp_y[k])) begin fails++; $display("FAIL gray_y step%0d got %0d want %0d", k, gy[2], exp_y[k]); end
      checks++; if ($countones(prev ^ gy[2]) != 1) begin fails++; $display("FAIL gray_onebit step%0d got %0d bits want 1", k, $countones(prev ^ gy[2])); end
      prev = gy[2];
    end
  endtask

  task automatic test_reset_mid();
    int exp_s[2] = '{1, 2};
    set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    tick();
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) ms[i] = 0;
    #1;
    checks++; if (gs[0] !== 3'd0) begin fails++; $display("FAIL midrst_s got %0d want 0", gs[0]); end
    checks++; if (gy[0] !== 3'd0) begin fails++; $display("FAIL midrst_y got %0d want 0", gy[0]); end
    checks++; if (gn[0] !== 3'd0) begin fails++; $display("FAIL midrst_n got %0d want 0", gn[0]); end
    checks++; if (gtc[0] !== 1'b0) begin fails++; $display("FAIL midrst_tc got %0b want 0", gtc[0]); end
    tick();
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (gs[0] !== 3'(exp_s[k])) begin fails++; $display("FAIL midrst_resume step%0d got %0d want %0d", k, gs[0], exp_s[k]); end
    end
  endtask

  task automatic test_limit_hold();
    set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    tick();
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
`ifdef UDC_SATURATE_EN
      checks++; if (gs[0] !== 3'd3) begin fails++; $display("FAIL sat_s step%0d got %0d want 3", k, gs[0]); end
      checks++; if (gtc[0] !== 1'b1) begin fails++; $display("FAIL sat_tc step%0d got %0b want 1", k, gtc[0]); end
`else
      checks++; if (gs[0] !== 3'(ms[0])) begin fails++; $display("FAIL limit_s step%0d got %0d want %0d", k, gs[0], ms[0]); end
      checks++; if (gtc[0] !== model_tc(0)) begin fails++; $display("FAIL limit_tc step%0d got %0b want %0b", k, gtc[0], model_tc(0)); end
`endif
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      set_inputs(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom));
      for (int i = 0; i < 3; i++) begin
        checks++; if (gn[i] !== 3'(model_next(i))) begin fails++; $display("FAIL rand_n cyc%0d dut%0d got %0d want %0d", k, i, gn[i], model_next(i)); end
        checks++; if (gtc[i] !== model_tc(i)) begin fails++; $display("FAIL rand_tc cyc%0d dut%0d got %0b want %0b", k, i, gtc[i], model_tc(i)); end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++; if (gs[i] !== 3'(ms[i])) begin fails++; $display("FAIL rand_s cyc%0d dut%0d got %0d want %0d", k, i, gs[i], ms[i]); end
        checks++; if (gy[i] !== 3'(model_y(i))) begin fails++; $display("FAIL rand_y cyc%0d dut%0d got %0d want %0d", k, i, gy[i], model_y(i)); end
      end
    end
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_mod3_down();
    test_load_priority();
    test_gray();
    test_reset_mid();
    test_limit_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
